// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS32 control sequencer: walks the shared datapath through
// FETCH/DECODE/EXECUTE/MEM/WB with memory wait states via mem_ready.
module multicycle_ctrl_fsm #(
  parameter int          STATE_W = 4,
  parameter logic [5:0]  OP_ADDI = 6'h08,
  parameter logic [5:0]  OP_J    = 6'h02
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               illegal_op,
  output logic               instr_done,
  output logic [STATE_W-1:0] state_dbg
);

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [STATE_W-1:0] {
    S_RST    = STATE_W'(0),
    S_FETCH  = STATE_W'(1),
    S_DECODE = STATE_W'(2),
    S_MADDR  = STATE_W'(3),
    S_MREAD  = STATE_W'(4),
    S_MWB    = STATE_W'(5),
    S_MWRITE = STATE_W'(6),
    S_REXEC  = STATE_W'(7),
    S_RWB    = STATE_W'(8),
    S_BEQ    = STATE_W'(9),
    S_JMP    = STATE_W'(10),
    S_IEXEC  = STATE_W'(11),
    S_IWB    = STATE_W'(12)
  } state_t;

  state_t state;
  logic   op_legal;

  assign op_legal = (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_R) ||
                    (opcode == OP_BEQ) || (opcode == OP_ADDI) || (opcode == OP_J);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RST;
    end else begin
      case (state)
        S_RST:    state <= S_FETCH;
        S_FETCH:  if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          if (opcode == OP_LW || opcode == OP_SW) state <= S_MADDR;
          else if (opcode == OP_R)                state <= S_REXEC;
          else if (opcode == OP_BEQ)              state <= S_BEQ;
          else if (opcode == OP_ADDI)             state <= S_IEXEC;
          else if (opcode == OP_J)                state <= S_JMP;
          else                                    state <= S_FETCH;
        end
        S_MADDR:  state <= (opcode == OP_SW) ? S_MWRITE : S_MREAD;
        S_MREAD:  if (mem_ready) state <= S_MWB;
        S_MWB:    state <= S_FETCH;
        S_MWRITE: if (mem_ready) state <= S_FETCH;
        S_REXEC:  state <= S_RWB;
        S_RWB:    state <= S_FETCH;
        S_BEQ:    state <= S_FETCH;
        S_JMP:    state <= S_FETCH;
        S_IEXEC:  state <= S_IWB;
        S_IWB:    state <= S_FETCH;
        default:  state <= S_RST;
      endcase
    end
  end

  // Control word is a pure decode of the state register; only the memory
  // handshake (and opcode legality in DECODE) feeds through combinationally.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;
    instr_done    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = 2'b11;
        illegal_op = ~op_legal;
      end
      S_MADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MREAD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MWRITE: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      S_REXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_RWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      S_JMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_IWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: directed and random instruction streams checked
// cycle by cycle against a phase-list model of each instruction class.
module tb_multicycle_ctrl_fsm;

  localparam int S_RST = 0, S_FETCH = 1, S_DECODE = 2, S_MADDR = 3, S_MREAD = 4,
                 S_MWB = 5, S_MWRITE = 6, S_REXEC = 7, S_RWB = 8, S_BEQ = 9,
                 S_JMP = 10, S_IEXEC = 11, S_IWB = 12;

  typedef struct packed {
    logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic illegal_op, instr_done;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, instr_done;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state_dbg;
  ctl_t       obs;

  int errors = 0;
  int checks = 0;
  int exp_done = 0, dut_done = 0;
  int exp_ill = 0, dut_ill = 0;
  logic [5:0] cur_op = 6'h00;

  multicycle_ctrl_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .instr_done(instr_done),
    .state_dbg(state_dbg)
  );

  assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                pc_source, illegal_op, instr_done};

  always #5 clk = ~clk;

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
  endfunction

  // Control word each state must present, straight from the state table.
  function automatic ctl_t exp_ctl(input int st, input logic mr, input logic [5:0] op);
    ctl_t c = '0;
    case (st)
      S_FETCH:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
      S_DECODE: begin c.alu_src_b = 2'b11; c.illegal_op = !is_legal(op); end
      S_MADDR:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      S_MREAD:  begin c.mem_read = 1; c.i_or_d = 1; end
      S_MWB:    begin c.reg_write = 1; c.mem_to_reg = 1; c.instr_done = 1; end
      S_MWRITE: begin c.mem_write = 1; c.i_or_d = 1; c.instr_done = mr; end
      S_REXEC:  begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      S_RWB:    begin c.reg_write = 1; c.reg_dst = 1; c.instr_done = 1; end
      S_BEQ:    begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1;
                      c.pc_source = 2'b01; c.instr_done = 1; end
      S_JMP:    begin c.pc_write = 1; c.pc_source = 2'b10; c.instr_done = 1; end
      S_IEXEC:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      S_IWB:    begin c.reg_write = 1; c.instr_done = 1; end
      default:  ;
    endcase
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs on the falling edge, then check the state
  // and control word the DUT presents for that cycle.
  task automatic cyc(input int st, input logic mr);
    ctl_t e;
    @(negedge clk);
    opcode = cur_op;
    mem_ready = mr;
    #1;
    e = exp_ctl(st, mr, cur_op);
    chk($sformatf("state(op=%h)", cur_op), 32'(state_dbg), 32'(st));
    chk($sformatf("ctl(st=%0d,mr=%0b)", st, mr), 32'(obs), 32'(e));
    chk("rd_wr_excl", 32'(mem_read & mem_write), 32'd0);
    chk("rw_wr_excl", 32'(reg_write & mem_write), 32'd0);
    if (instr_done === 1'b1) dut_done++;
    if (illegal_op === 1'b1) dut_ill++;
  endtask

  // Memory-handshake state: 'waits' stall cycles then the completing cycle.
  task automatic mem_phase(input int st, input int waits);
    for (int i = 0; i < waits; i++) cyc(st, 1'b0);
    cyc(st, 1'b1);
  endtask

  function automatic int rw();
    return int'($urandom_range(0, 3));
  endfunction

  // Expected phase sequence for one instruction, by instruction class.
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
    cur_op = op;
    mem_phase(S_FETCH, wf);
    cyc(S_DECODE, 1'($urandom));
    case (op)
      6'h23: begin cyc(S_MADDR, 1'($urandom)); mem_phase(S_MREAD, wm); cyc(S_MWB, 1'($urandom)); end
      6'h2B: begin cyc(S_MADDR, 1'($urandom)); mem_phase(S_MWRITE, wm); end
      6'h00: begin cyc(S_REXEC, 1'($urandom)); cyc(S_RWB, 1'($urandom)); end
      6'h04: cyc(S_BEQ, 1'($urandom));
      6'h08: begin cyc(S_IEXEC, 1'($urandom)); cyc(S_IWB, 1'($urandom)); end
      6'h02: cyc(S_JMP, 1'($urandom));
      default: ;
    endcase
    if (is_legal(op)) exp_done++;
    else exp_ill++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] op;
    logic [5:0] legal [6];
    legal = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
    rst = 1'b1; opcode = 6'h00; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_state", 32'(state_dbg), 32'd0);
    chk("reset_ctl", 32'(obs), 32'd0);

    // Directed cases.
    run_instr(6'h00, 0, 0);   // R-type: 1,2,7,8
    run_instr(6'h23, 0, 3);   // lw with three stalls in MREAD
    run_instr(6'h2B, 0, 0);   // sw completes first cycle
    run_instr(6'h3F, 0, 0);   // illegal
    run_instr(6'h04, 0, 0);   // beq
    run_instr(6'h02, 0, 0);   // j
    run_instr(6'h08, 2, 0);   // addi with fetch stalls
    run_instr(6'h2B, 1, 3);   // sw with write stalls

    // Reset during an MWRITE wait aborts the store.
    cur_op = 6'h2B;
    cyc(S_FETCH, 1'b1);
    cyc(S_DECODE, 1'b1);
    cyc(S_MADDR, 1'b1);
    cyc(S_MWRITE, 1'b0);
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_state", 32'(state_dbg), 32'd0);
    chk("abort_mem_write", 32'(mem_write), 32'd0);
    chk("abort_ctl", 32'(obs), 32'd0);
    rst = 1'b0;

    // Random instruction stream with random memory stalls.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do op = 6'($urandom); while (is_legal(op));
      end else begin
        op = legal[$urandom_range(0, 5)];
      end
      run_instr(op, rw(), rw());
    end

    chk("instr_done_count", 32'(dut_done), 32'(exp_done));
    chk("illegal_count", 32'(dut_ill), 32'(exp_ill));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
